// File: rtl/pll_lock_sequencer.sv
// Sequences the PLL reset/lock handshake on the free-running board clock and
// releases the downstream system reset once lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 60,
  parameter int LOCK_TIMEOUT  = 600000,
  parameter int STABLE_CYCLES = 6000,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] relock_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       relock_q, relock_d;
  logic             sync1_q, lock_s_q;
  logic             pll_reset_q, sys_rst_n_q, locked_q, fault_q;

  // In RUN the phase counter doubles as the consecutive-low filter.
  always_comb begin
    // NOTE: every always_comb target is defaulted first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    if (restart) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RESET_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          cnt_d = '0;
          if (lock_s_q) begin
            state_d = STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = HOLD;
              retry_d = retry_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABILIZE: begin
          cnt_d = '0;
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!lock_s_q) begin
            if (cnt_q == LOSS_LAST) begin
              state_d = HOLD;
              if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FAULT: cnt_d = '0;
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, which keeps the synchronizer two stages deep.
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_reset_q <= (state_d == HOLD) || (state_d == FAULT);
      sys_rst_n_q <= (state_d == RUN);
      locked_q    <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_reset  = pll_reset_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign relock_cnt = relock_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: vector table, directed corner sequences and a
// randomized run compared against a timestamp-based reference model.
module tb_pll_lock_sequencer;

  localparam int R = 4, T = 20, S = 8, L = 3, M = 2;
  localparam int H = 0, W = 1, ST = 2, RN = 3, F = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sys_rst_n, locked, fault;
  logic [1:0] retry_cnt;
  logic [7:0] relock_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S),
    .LOSS_FILTER(L), .MAX_RETRIES(M), .CNT_W(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault),
    .retry_cnt(retry_cnt), .relock_cnt(relock_cnt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pk(input int st, input logic pr, input logic sr,
                                     input logic lk, input logic ft, input int rt, input int rl);
    return {3'(st), pr, sr, lk, ft, 2'(rt), 8'(rl)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {state, pll_reset, sys_rst_n, locked, fault, retry_cnt, relock_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input int s, input int max_cyc, output int n);
    n = 0;
    while (state !== 3'(s) && n < max_cyc) begin
      cycles(1);
      n++;
    end
  endtask

  // Reference model: phases are tracked by the edge at which they were entered,
  // and the synchronizer is a short history of sampled pll_lock values.
  int cyc = 0, since = 0, last_hi = 0;
  int m_state = 0, m_retry = 0, m_relock = 0;
  bit raw_q[$];

  task automatic model_go(input int s);
    m_state = s;
    since   = cyc;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state  = H;
      since    = cyc;
      m_retry  = 0;
      m_relock = 0;
      raw_q.delete();
    end else begin
      bit ls;
      int el;
      int lo_from;
      cyc++;
      ls = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
      raw_q.push_back(pll_lock);
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      if (ls) last_hi = cyc;
      el = cyc - since;
      if (restart) begin
        model_go(H);
        m_retry = 0;
      end else begin
        case (m_state)
          H:  if (el == R) model_go(W);
          W: begin
            if (ls) model_go(ST);
            else if (el == T) begin
              if (m_retry == M) model_go(F);
              else begin
                m_retry++;
                model_go(H);
              end
            end
          end
          ST: begin
            if (!ls) model_go(W);
            else if (el == S) begin
              m_retry = 0;
              model_go(RN);
            end
          end
          RN: begin
            lo_from = (last_hi > since) ? last_hi : since;
            if (cyc - lo_from == L) begin
              if (m_relock < 255) m_relock++;
              model_go(H);
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [16:0] model_vec();
    return pk(m_state, (m_state == H) || (m_state == F), m_state == RN, m_state == RN,
              m_state == F, m_retry, m_relock);
  endfunction

  typedef struct {
    logic        rst_n;
    logic        rst_req;
    logic        lock;
    int          ncyc;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int  n;
    int  bad;
    int  seg;
    bit  lvl;

    tbl.push_back('{1'b0, 1'b0, 1'b0,  2, pk(H, 1, 0, 0, 0, 0, 0), "reset values"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  3, pk(H, 1, 0, 0, 0, 0, 0), "hold attempt0"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  1, pk(W, 0, 0, 0, 0, 0, 0), "wait attempt0"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 19, pk(W, 0, 0, 0, 0, 0, 0), "wait before timeout0"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  1, pk(H, 1, 0, 0, 0, 1, 0), "timeout0 to hold"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  3, pk(H, 1, 0, 0, 0, 1, 0), "hold attempt1"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  1, pk(W, 0, 0, 0, 0, 1, 0), "wait attempt1"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 20, pk(H, 1, 0, 0, 0, 2, 0), "timeout1 to hold"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  4, pk(W, 0, 0, 0, 0, 2, 0), "wait attempt2"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 19, pk(W, 0, 0, 0, 0, 2, 0), "wait before final timeout"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  1, pk(F, 1, 0, 0, 1, 2, 0), "fault entry"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, pk(F, 1, 0, 0, 1, 2, 0), "fault holds"});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, pk(H, 1, 0, 0, 0, 0, 0), "restart from fault"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  3, pk(H, 1, 0, 0, 0, 0, 0), "hold after restart"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  1, pk(W, 0, 0, 0, 0, 0, 0), "wait after restart"});
    tbl.push_back('{1'b1, 1'b0, 1'b1,  2, pk(W, 0, 0, 0, 0, 0, 0), "lock in synchronizer"});
    tbl.push_back('{1'b1, 1'b0, 1'b1,  1, pk(ST, 0, 0, 0, 0, 0, 0), "stabilize entry"});
    tbl.push_back('{1'b1, 1'b0, 1'b1,  7, pk(ST, 0, 0, 0, 0, 0, 0), "stabilize counting"});
    tbl.push_back('{1'b1, 1'b0, 1'b1,  1, pk(RN, 0, 1, 1, 0, 0, 0), "run release"});

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n  = tbl[i].rst_n;
      restart  = tbl[i].rst_req;
      pll_lock = tbl[i].lock;
      cycles(tbl[i].ncyc);
      check(tbl[i].name, dut_vec(), tbl[i].exp);
    end
    restart = 1'b0;

    // Normal bring-up: pll_reset width and lock-to-release latency.
    pll_lock = 1'b0;
    reset_n  = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    n = 0;
    while (pll_reset === 1'b1 && n < 50) begin
      n++;
      cycles(1);
    end
    check("bringup pll_reset width", n, 4);
    cycles(5);
    pll_lock = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 50) begin
      cycles(1);
      n++;
    end
    check("bringup release latency", n, 11);
    check("bringup locked", locked, 1);
    check("bringup retry_cnt", retry_cnt, 0);

    // Stabilize abort: 5 high, 1 low, then high again.
    pll_lock = 1'b0;
    reset_n  = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    wait_state(W, 50, n);
    check("abort reach wait_lock", state, W);
    pll_lock = 1'b1;
    cycles(5);
    pll_lock = 1'b0;
    cycles(1);
    pll_lock = 1'b1;
    cycles(2);
    check("abort back to wait_lock", state, W);
    cycles(1);
    check("abort re-enter stabilize", state, ST);
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 50) begin
      cycles(1);
      n++;
    end
    check("abort release latency", 3 + n, 11);

    // Loss filter: a 2-cycle glitch is absorbed, a 3-cycle low is a loss.
    bad = 0;
    pll_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) pll_lock = 1'b1;
      cycles(1);
      if (state !== 3'(RN) || locked !== 1'b1 || sys_rst_n !== 1'b1) bad++;
    end
    check("glitch keeps run", bad, 0);
    check("glitch relock_cnt", relock_cnt, 0);
    pll_lock = 1'b0;
    wait_state(H, 20, n);
    check("loss detect latency", n, 5);
    check("loss outputs", dut_vec(), pk(H, 1, 0, 0, 0, 0, 1));
    pll_lock = 1'b1;
    wait_state(RN, 100, n);
    check("loss resequence", dut_vec(), pk(RN, 0, 1, 1, 0, 0, 1));

    // restart in RUN with lock still high.
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    check("restart in run", dut_vec(), pk(H, 1, 0, 0, 0, 0, 1));

    // Async reset in RUN and in STABILIZE, observed with no clock edge.
    wait_state(RN, 100, n);
    check("reach run before reset", state, RN);
    #2 reset_n = 1'b0;
    #1 check("async reset in run", dut_vec(), pk(H, 1, 0, 0, 0, 0, 0));
    @(negedge clk) reset_n = 1'b1;
    wait_state(ST, 100, n);
    cycles(2);
    check("reach stabilize before reset", state, ST);
    #2 reset_n = 1'b0;
    #1 check("async reset in stabilize", dut_vec(), pk(H, 1, 0, 0, 0, 0, 0));
    @(negedge clk) reset_n = 1'b1;

    // Randomized run against the reference model.
    pll_lock = 1'b0;
    reset_n  = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    seg = 0;
    lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      check("random cycle", dut_vec(), model_vec());
      if (seg == 0) begin
        lvl = ($urandom_range(0, 2) != 0);
        seg = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 70));
      end
      pll_lock = lvl;
      seg--;
      restart = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences the rPLL reset/lock handshake and releases the downstream system reset only after the PLL lock has been stable for a programmed time. It runs on the free-running 60 MHz board clock, not on the PLL output. It drives the PLL RESET pin and takes the PLL LOCK pin. It retries failed lock attempts, detects loss of lock in operation, and latches a fault after repeated failures.

Parameters:
RESET_CYCLES, 60, cycles the PLL reset is held high per attempt (1 us at 60 MHz)
LOCK_TIMEOUT, 600000, cycles allowed in WAIT_LOCK before the attempt fails (10 ms)
STABLE_CYCLES, 6000, consecutive synced-lock-high cycles required before release (100 us)
LOSS_FILTER, 4, consecutive synced-lock-low cycles in RUN that count as loss of lock
MAX_RETRIES, 3, failed attempts tolerated before FAULT
CNT_W, 20, width of the shared phase counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
clk  in  1  free-running 60 MHz reference clock (same net as PLL clkin)
reset_n  in  1  asynchronous active-low reset
restart  in  1  single-cycle pulse that forces a fresh sequence from any state
pll_lock  in  1  PLL LOCK output, asynchronous to clk
pll_reset  out  1  drives PLL RESET, active-high
sys_rst_n  out  1  downstream reset, active-low, deasserts synchronous to clk
locked  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_cnt  out  2  failed attempts in the current sequence
relock_cnt  out  8  loss-of-lock events since reset_n, saturating at 255
state  out  3  HOLD=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4

Behaviour:
- reset_n low (async): state=HOLD, phase counter=0, pll_reset=1, sys_rst_n=0, locked=0, fault=0, retry_cnt=0, relock_cnt=0, sync flops=0.
- pll_lock passes through a 2-FF synchronizer to produce lock_s. All decisions use lock_s only.
- All outputs are registered and are decoded from the next state, so each output changes on the same edge as the state.
- HOLD: pll_reset=1. The counter runs 0..RESET_CYCLES-1, then the block goes to WAIT_LOCK with cnt=0.
- WAIT_LOCK: pll_reset=0.
  - If lock_s=1, go to STABILIZE with cnt=0.
  - Else, at cnt==LOCK_TIMEOUT-1 the attempt fails:
    - if retry_cnt==MAX_RETRIES, go to FAULT;
    - otherwise increment retry_cnt and go to HOLD.
- STABILIZE:
  - If lock_s=0, go back to WAIT_LOCK with cnt=0 and a fresh timeout.
  - At cnt==STABLE_CYCLES-1 with lock_s=1, go to RUN and clear retry_cnt.
- RUN: sys_rst_n=1, locked=1. A low counter counts consecutive lock_s=0 cycles and clears on any lock_s=1.
  - When the low counter reaches LOSS_FILTER, increment relock_cnt (saturating) and go to HOLD. sys_rst_n and locked drop on that same edge.
  - Low glitches shorter than LOSS_FILTER cycles cause no visible effect.
- FAULT: pll_reset=1, sys_rst_n=0, fault=1. The block stays here until restart or reset_n.
- restart=1 takes priority over every other transition, in any state:
  - go to HOLD, cnt=0, retry_cnt=0, fault=0;
  - relock_cnt is preserved.
- sys_rst_n=0 in every state except RUN.
- Latency from pll_lock rising while in WAIT_LOCK to sys_rst_n rising: exactly STABLE_CYCLES+3 clk edges (2 sync, 1 WAIT_LOCK to STABILIZE, STABLE_CYCLES).
- pll_lock already high at the exit from HOLD is a valid case: STABILIZE is entered on the first WAIT_LOCK cycle in which lock_s=1.
- The phase counter must never wrap. Each state clears it on entry.

Test Plan:
- Overrides for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_FILTER=3, MAX_RETRIES=2.
- Normal bring-up: release reset_n, then raise pll_lock 5 cycles after pll_reset falls -> pll_reset is high for exactly 4 cycles; sys_rst_n and locked rise 11 edges after pll_lock rises; retry_cnt=0.
- Stabilize abort: pll_lock high for 5 cycles, low for 1, then high -> state returns to WAIT_LOCK then STABILIZE; release occurs 11 edges after the second rise.
- Retry and fault: pll_lock held low -> three HOLD/WAIT_LOCK cycles with retry_cnt 0,1,2; then FAULT with fault=1, pll_reset=1, sys_rst_n=0; a restart pulse -> HOLD, fault=0, retry_cnt=0.
- Loss filter in RUN: a 2-cycle pll_lock low glitch -> remains in RUN, relock_cnt=0. A 3-cycle low -> HOLD, sys_rst_n=0, relock_cnt=1, followed by a full re-sequence.
- Async reset mid-operation: assert reset_n during STABILIZE and during RUN -> all outputs take their reset values immediately without a clock; relock_cnt=0.
- restart in RUN: pulse restart with pll_lock high -> HOLD on the next edge, sys_rst_n=0, relock_cnt unchanged.
